// File: rtl/button_event_arbiter_if.sv
// Button/event bundle between the button event arbiter and its consumer side.
// The master modport is the arbiter; the slave modport is the consumer and button source.
interface button_event_arbiter_if #(
   parameter int unsigned N_BTN = 4
) ();
   logic [N_BTN-1:0] buttons;
   logic             ev_valid;
   logic [2:0]       ev_id;
   logic             ev_ready;
   logic [N_BTN-1:0] pending;
   logic [N_BTN-1:0] toggle_state;
   logic [7:0]       drop_count;

   modport master (
      input  buttons,
      input  ev_ready,
      output ev_valid,
      output ev_id,
      output pending,
      output toggle_state,
      output drop_count
   );

   modport slave (
      output buttons,
      output ev_ready,
      input  ev_valid,
      input  ev_id,
      input  pending,
      input  toggle_state,
      input  drop_count
   );
endinterface

// File: rtl/button_event_arbiter.sv
// Round-robin arbiter that turns button presses into one-at-a-time valid/ready events,
// keeping a pending flag and a toggle bit per button and counting lost presses.
// Optional input debouncing is enabled by defining BTN_DEBOUNCE_EN.
module button_event_arbiter #(
   parameter int unsigned N_BTN    = 4,
   parameter int unsigned TIMEOUT  = 15,
   parameter int unsigned DEBOUNCE = 4
) (
   input logic                   clk,
   input logic                   rst,
   button_event_arbiter_if.master bus
);

   typedef enum logic [0:0] {StIdle, StOffer} state_e;

   if (N_BTN < 2 || N_BTN > 8 || TIMEOUT < 1 || TIMEOUT > 255 ||
       DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_bad_param
      $error("button_event_arbiter: parameter out of legal range");
   end

   state_e           r_state, w_state_nxt;
   logic [2:0]       r_ev_id, w_ev_id_nxt;
   logic [2:0]       r_ptr, w_ptr_nxt;
   logic [7:0]       r_timer, w_timer_nxt;
   logic [N_BTN-1:0] r_pending, w_pending_nxt;
   logic [N_BTN-1:0] r_toggle, w_toggle_nxt;
   logic [7:0]       r_drop, w_drop_nxt;
   logic [N_BTN-1:0] r_btn_q, r_btn_qq;
   logic [N_BTN-1:0] w_rise;
   logic             w_accept;
   logic             w_any_drop;
   logic             w_found;
   logic [2:0]       w_sel;
   logic [2:0]       w_id_inc;

`ifdef BTN_DEBOUNCE_EN
   logic [N_BTN-1:0][7:0] r_db_cnt;

   // Debounced sampling: adopt a new level only after it has persisted DEBOUNCE edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btn_q  <= '0;
         r_db_cnt <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            if (bus.buttons[i] == r_btn_q[i]) begin
               r_db_cnt[i] <= 8'd0;
            end else if (r_db_cnt[i] == 8'(DEBOUNCE - 1)) begin
               r_btn_q[i]  <= bus.buttons[i];
               r_db_cnt[i] <= 8'd0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + 8'd1;
            end
         end
      end
   end
`else
   // Plain single-stage sampling of the raw button levels.
   always_ff @(posedge clk) begin
      if (rst) r_btn_q <= '0;
      else     r_btn_q <= bus.buttons;
   end
`endif

   // Delayed copy of the sampled levels for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) r_btn_qq <= '0;
      else     r_btn_qq <= r_btn_q;
   end

   assign w_rise   = r_btn_q & ~r_btn_qq;
   assign w_id_inc = (r_ev_id == 3'(N_BTN - 1)) ? 3'd0 : r_ev_id + 3'd1;

   // Round-robin pick: first pending bit at or above ptr, else first one below it.
   always_comb begin
      w_found = 1'b0;
      w_sel   = 3'd0;
      for (int i = 0; i < N_BTN; i++) begin
         if (!w_found && r_pending[i] && (3'(i) >= r_ptr)) begin
            w_found = 1'b1;
            w_sel   = 3'(i);
         end
      end
      for (int i = 0; i < N_BTN; i++) begin
         if (!w_found && r_pending[i] && (3'(i) < r_ptr)) begin
            w_found = 1'b1;
            w_sel   = 3'(i);
         end
      end
   end

   // Offer FSM next state: accept, timeout withdraw, or keep waiting.
   always_comb begin
      w_state_nxt  = r_state;
      w_ev_id_nxt  = r_ev_id;
      w_ptr_nxt    = r_ptr;
      w_timer_nxt  = r_timer;
      w_toggle_nxt = r_toggle;
      w_accept     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_found) begin
               w_state_nxt = StOffer;
               w_ev_id_nxt = w_sel;
               w_timer_nxt = 8'd0;
            end
         end
         StOffer: begin
            if (bus.ev_ready) begin
               w_accept = 1'b1;
               for (int i = 0; i < N_BTN; i++) begin
                  if (r_ev_id == 3'(i)) w_toggle_nxt[i] = ~r_toggle[i];
               end
               w_ptr_nxt   = w_id_inc;
               w_state_nxt = StIdle;
            end else if (r_timer == 8'(TIMEOUT - 1)) begin
               w_ptr_nxt   = w_id_inc;
               w_state_nxt = StIdle;
            end else begin
               w_timer_nxt = r_timer + 8'd1;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Pending flags and drop counter; a press coinciding with its own accept re-arms.
   always_comb begin
      w_pending_nxt = r_pending;
      w_any_drop    = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (w_rise[i]) begin
            w_pending_nxt[i] = 1'b1;
            if (r_pending[i] && !(w_accept && (r_ev_id == 3'(i)))) w_any_drop = 1'b1;
         end else if (w_accept && (r_ev_id == 3'(i))) begin
            w_pending_nxt[i] = 1'b0;
         end
      end
      w_drop_nxt = (w_any_drop && (r_drop != 8'hFF)) ? r_drop + 8'd1 : r_drop;
   end

   // State register for the FSM and all arbitration bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= StIdle;
         r_ev_id   <= 3'd0;
         r_ptr     <= 3'd0;
         r_timer   <= 8'd0;
         r_pending <= '0;
         r_toggle  <= '0;
         r_drop    <= 8'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_ev_id   <= w_ev_id_nxt;
         r_ptr     <= w_ptr_nxt;
         r_timer   <= w_timer_nxt;
         r_pending <= w_pending_nxt;
         r_toggle  <= w_toggle_nxt;
         r_drop    <= w_drop_nxt;
      end
   end

   assign bus.ev_valid     = (r_state == StOffer);
   assign bus.ev_id        = r_ev_id;
   assign bus.pending      = r_pending;
   assign bus.toggle_state = r_toggle;
   assign bus.drop_count   = r_drop;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a behavioural model.
module tb_button_event_arbiter;
   localparam int unsigned N  = 4;
   localparam int unsigned TO = 15;
   localparam int unsigned DB = 4;

   logic clk = 1'b0;
   logic rst;
   bit   cmp_en = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   button_event_arbiter_if #(.N_BTN(N)) bus ();

   button_event_arbiter #(
      .N_BTN   (N),
      .TIMEOUT (TO),
      .DEBOUNCE(DB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: state of the world described with plain arrays and integers.
   bit m_bq[N], m_bqq[N], m_pend[N], m_tog[N];
   int m_cnt[N];
   int m_drop, m_ptr, m_id, m_timer;
   bit m_offer;

   function automatic int pack(input bit a[N]);
      int v = 0;
      for (int i = 0; i < N; i++) if (a[i]) v += (1 << i);
      return v;
   endfunction

   always @(posedge clk) begin : model
      bit old_pend[N];
      bit rise[N];
      bit acc, drop, found;
      int acc_id;
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_bq[i] = 0; m_bqq[i] = 0; m_pend[i] = 0; m_tog[i] = 0; m_cnt[i] = 0;
         end
         m_drop = 0; m_ptr = 0; m_id = 0; m_timer = 0; m_offer = 0;
      end else begin
         old_pend = m_pend;
         for (int i = 0; i < N; i++) rise[i] = m_bq[i] && !m_bqq[i];
         acc    = m_offer && (bus.ev_ready === 1'b1);
         acc_id = m_id;
         if (!m_offer) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               int j;
               j = (m_ptr + k) % N;
               if (!found && old_pend[j]) begin
                  found = 1; m_offer = 1; m_id = j; m_timer = 0;
               end
            end
         end else if (acc) begin
            m_tog[m_id] = !m_tog[m_id];
            m_ptr = (m_id + 1) % N;
            m_offer = 0;
         end else if (m_timer == TO - 1) begin
            m_ptr = (m_id + 1) % N;
            m_offer = 0;
         end else begin
            m_timer++;
         end
         drop = 0;
         for (int i = 0; i < N; i++) begin
            if (rise[i]) begin
               if (old_pend[i] && !(acc && acc_id == i)) drop = 1;
               m_pend[i] = 1;
            end else if (acc && acc_id == i) begin
               m_pend[i] = 0;
            end
         end
         if (drop && m_drop < 255) m_drop++;
         for (int i = 0; i < N; i++) m_bqq[i] = m_bq[i];
         for (int i = 0; i < N; i++) begin
`ifdef BTN_DEBOUNCE_EN
            if (bus.buttons[i] == m_bq[i]) m_cnt[i] = 0;
            else if (m_cnt[i] == DB - 1) begin m_bq[i] = bus.buttons[i]; m_cnt[i] = 0; end
            else m_cnt[i]++;
`else
            m_bq[i] = bus.buttons[i];
`endif
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("ev_valid", int'(bus.ev_valid), int'(m_offer));
         if (m_offer) check("ev_id", int'(bus.ev_id), m_id);
         check("pending", int'(bus.pending), pack(m_pend));
         check("toggle_state", int'(bus.toggle_state), pack(m_tog));
         check("drop_count", int'(bus.drop_count), m_drop);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; bus.buttons = '0; bus.ev_ready = 1'b0;
      cyc(1);
      rst = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n = 0;
      while (!bus.ev_valid && n < 30) begin cyc(1); n++; end
      check(name, int'(bus.ev_valid), 1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int q[$];
      int cnt, mode, first_e;
      int exp_order[3] = '{0, 2, 0};
      rst = 1'b1; bus.buttons = '0; bus.ev_ready = 1'b0;
      cyc(2);
      cmp_en = 1'b1;
      rst = 1'b0;
      check("rst_valid", int'(bus.ev_valid), 0);
      check("rst_id", int'(bus.ev_id), 0);
      check("rst_pending", int'(bus.pending), 0);
      check("rst_toggle", int'(bus.toggle_state), 0);
      check("rst_drop", int'(bus.drop_count), 0);

`ifndef BTN_DEBOUNCE_EN
      // Single press with consumer always ready.
      bus.buttons = 4'b0010; bus.ev_ready = 1'b1;
      cyc(2);
      check("single_pending", int'(bus.pending), 2);
      check("single_valid_early", int'(bus.ev_valid), 0);
      cyc(1);
      check("single_valid", int'(bus.ev_valid), 1);
      check("single_id", int'(bus.ev_id), 1);
      cyc(1);
      check("single_toggle", int'(bus.toggle_state), 2);
      check("single_pending_clr", int'(bus.pending), 0);
      bus.buttons = '0;
      cyc(3);

      // Round-robin: 0 and 2 together, then 0 again.
      do_reset();
      bus.buttons = 4'b0101; bus.ev_ready = 1'b1;
      cyc(1);
      bus.buttons = '0;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (bus.ev_valid) q.push_back(int'(bus.ev_id));
         if (i == 1) bus.buttons = 4'b0001;
         if (i == 2) bus.buttons = 4'b0000;
      end
      check("rr_grant_count", q.size(), 3);
      for (int k = 0; k < 3; k++) check("rr_grant_order", (k < q.size()) ? q[k] : -1, exp_order[k]);
      check("rr_toggle", int'(bus.toggle_state), 4);

      // Timeout withdraw and re-offer.
      bus.ev_ready = 1'b0; bus.buttons = 4'b1000;
      cyc(1);
      bus.buttons = '0;
      wait_valid("to_first_offer");
      cnt = 0;
      while (bus.ev_valid && cnt < 40) begin cnt++; cyc(1); end
      check("to_high_cycles", cnt, 15);
      check("to_gap_valid", int'(bus.ev_valid), 0);
      check("to_pending_kept", int'(bus.pending[3]), 1);
      check("to_toggle_same", int'(bus.toggle_state), 4);
      cyc(1);
      check("to_reoffer_valid", int'(bus.ev_valid), 1);
      check("to_reoffer_id", int'(bus.ev_id), 3);
      bus.ev_ready = 1'b1;
      cyc(1);
      check("to_accept_toggle", int'(bus.toggle_state), 12);
      bus.ev_ready = 1'b0;

      // Reset in the middle of an offer.
      bus.buttons = 4'b0100;
      cyc(1);
      bus.buttons = '0;
      wait_valid("rmo_offer");
      rst = 1'b1;
      cyc(1);
      check("rmo_valid", int'(bus.ev_valid), 0);
      check("rmo_id", int'(bus.ev_id), 0);
      check("rmo_pending", int'(bus.pending), 0);
      check("rmo_toggle", int'(bus.toggle_state), 0);
      rst = 1'b0;

      // Drop counting and saturation.
      for (int k = 0; k < 3; k++) begin
         bus.buttons = 4'b0010; cyc(1);
         bus.buttons = 4'b0000; cyc(1);
      end
      cyc(2);
      check("drop_two", int'(bus.drop_count), 2);
      check("drop_pending", int'(bus.pending[1]), 1);
      for (int k = 0; k < 300; k++) begin
         bus.buttons = 4'b0010; cyc(1);
         bus.buttons = 4'b0000; cyc(1);
      end
      cyc(2);
      check("drop_saturate", int'(bus.drop_count), 255);
      bus.ev_ready = 1'b1;
      cyc(4);

      // Accept coinciding with a re-press of the same button.
      do_reset();
      bus.buttons = 4'b0010;
      cyc(1);
      bus.buttons = '0;
      wait_valid("sim_offer");
      bus.buttons = 4'b0010;
      cyc(1);
      bus.ev_ready = 1'b1; bus.buttons = '0;
      cyc(1);
      check("sim_toggle", int'(bus.toggle_state), 2);
      check("sim_pending", int'(bus.pending), 2);
      check("sim_drop", int'(bus.drop_count), 0);
      check("sim_idle", int'(bus.ev_valid), 0);
      cyc(1);
      check("sim_reoffer_valid", int'(bus.ev_valid), 1);
      check("sim_reoffer_id", int'(bus.ev_id), 1);
      bus.ev_ready = 1'b0;
`else
      // Debounce: short glitch ignored, full-length pulse registers after DEBOUNCE+1 edges.
      bus.buttons = 4'b0001;
      cyc(3);
      bus.buttons = '0;
      cyc(10);
      check("db_glitch_pending", int'(bus.pending), 0);
      bus.buttons = 4'b0010;
      first_e = -1;
      for (int e = 1; e <= 12; e++) begin
         cyc(1);
         if (first_e < 0 && bus.pending[1]) first_e = e;
         if (e == 4) bus.buttons = '0;
      end
      check("db_pulse_latency", first_e, 5);
`endif

      // Randomized traffic against the model.
      do_reset();
      mode = 0;
      for (int c = 0; c < 4000; c++) begin
         cyc(1);
         if (c % 200 == 0) mode = $urandom_range(0, 2);
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 7) == 0) bus.buttons[i] = ~bus.buttons[i];
         case (mode)
            0:       bus.ev_ready = ($urandom_range(0, 3) != 0);
            1:       bus.ev_ready = ($urandom_range(0, 15) == 0);
            default: bus.ev_ready = $urandom_range(0, 1) == 1;
         endcase
         rst = ($urandom_range(0, 499) == 0);
      end
      rst = 1'b0;
      cyc(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
